// File: rtl/mult_seq_coef_pkg.sv
// Shared types and helpers for the sequential run-time-coefficient multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MASK_WIDTH = 64;

  // Counter width for a given coefficient width; never narrower than one bit
  function automatic int cnt_width(input int coef_width);
    return (coef_width > 1) ? $clog2(coef_width) : 1;
  endfunction

  // Ones in columns [out_width-1:trunc_bits], zeros in the truncated low columns
  function automatic logic [MASK_WIDTH-1:0] trunc_mask(input int trunc_bits, input int out_width);
    logic [MASK_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (i >= trunc_bits && i < out_width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mult_seq_coef_pp_gen.sv
// Partial-product generator: one shifted, masked, optionally negated addend per coefficient bit.
module mult_pp_gen
  import mult_seq_pkg::*;
#(
  parameter int BIT_WIDTH  = 5,
  parameter int OUT_WIDTH  = 13,
  parameter int TRUNC_BITS = 0,
  parameter int CNT_WIDTH  = 3
) (
  input  logic signed [BIT_WIDTH-1:0] inp,
  input  logic        [CNT_WIDTH-1:0] k,
  input  logic                        coef_bit,
  input  logic                        sign_bit,
  output logic signed [OUT_WIDTH-1:0] addend
);

  localparam logic [OUT_WIDTH-1:0] MASK = OUT_WIDTH'(trunc_mask(TRUNC_BITS, OUT_WIDTH));

  logic signed [OUT_WIDTH-1:0] ext;
  logic signed [OUT_WIDTH-1:0] pp;

  // The coefficient sign bit carries negative weight, so its partial product is subtracted
  always_comb begin
    ext    = OUT_WIDTH'(inp);
    pp     = (ext << k) & MASK;
    addend = '0;
    if (coef_bit) addend = sign_bit ? -pp : pp;
  end

endmodule

// File: rtl/mult_seq_coef.sv
// Radix-2 shift-add signed multiplier with a run-time coefficient and valid/ready handshakes.
module mult_seq_coef
  import mult_seq_pkg::*;
#(
  parameter int BIT_WIDTH  = 5,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = BIT_WIDTH + COEF_WIDTH,
  parameter int TRUNC_BITS = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [BIT_WIDTH-1:0]  inp,
  input  logic signed [COEF_WIDTH-1:0] coef,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [OUT_WIDTH-1:0]  out,
  output logic                         busy
);

  localparam int                   CNT_WIDTH = cnt_width(COEF_WIDTH);
  localparam logic [CNT_WIDTH-1:0] LAST      = CNT_WIDTH'(COEF_WIDTH - 1);

  state_t                      state;
  state_t                      state_next;
  logic        [CNT_WIDTH-1:0] cnt;
  logic signed [OUT_WIDTH-1:0] acc;
  logic signed [OUT_WIDTH-1:0] addend;
  logic signed [OUT_WIDTH-1:0] sum;
  logic signed [BIT_WIDTH-1:0] inp_q;
  logic       [COEF_WIDTH-1:0] coef_q;
  logic                        last_bit;
  logic                        accept;

  mult_pp_gen #(
    .BIT_WIDTH (BIT_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .TRUNC_BITS(TRUNC_BITS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_pp_gen (
    .inp     (inp_q),
    .k       (cnt),
    .coef_bit(coef_q[cnt]),
    .sign_bit(last_bit),
    .addend  (addend)
  );

  assign sum = acc + addend;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // in_ready is masked by rst so nothing is accepted on the reset edge
  always_comb begin
    state_next = state;
    in_ready   = (state == IDLE) && !rst;
    busy       = (state == BUSY);
    out_valid  = (state == DONE);
    last_bit   = (cnt == LAST);
    accept     = in_valid && in_ready;
    unique case (state)
      IDLE:    if (accept)    state_next = BUSY;
      BUSY:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // out is a separate register so it survives the accumulator clear on the next accept
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      out    <= '0;
      inp_q  <= '0;
      coef_q <= '0;
    end else if (accept) begin
      inp_q  <= inp;
      coef_q <= coef;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc <= sum;
      if (last_bit) begin
        out <= sum;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_coef.sv
// Directed and randomised self-checking bench for mult_seq_coef (exact and truncated instances).
module tb_mult_seq_coef;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [4:0]  inp;
  logic signed [7:0]  coef;
  logic               out_valid;
  logic               out_ready;
  logic signed [12:0] out;
  logic               busy;

  logic               t_in_valid;
  logic               t_in_ready;
  logic signed [4:0]  t_inp;
  logic signed [7:0]  t_coef;
  logic               t_out_valid;
  logic               t_out_ready;
  logic signed [12:0] t_out;
  logic               t_busy;

  int errors = 0;
  int checks = 0;

  mult_seq_coef #(.BIT_WIDTH(5), .COEF_WIDTH(8), .TRUNC_BITS(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inp(inp), .coef(coef), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
  );

  mult_seq_coef #(.BIT_WIDTH(5), .COEF_WIDTH(8), .TRUNC_BITS(2)) dut_trunc (
    .clk(clk), .rst(rst), .in_valid(t_in_valid), .in_ready(t_in_ready),
    .inp(t_inp), .coef(t_coef), .out_valid(t_out_valid), .out_ready(t_out_ready),
    .out(t_out), .busy(t_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [12:0] obs, input logic [12:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic checkFlag(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present an operand pair and return at the falling edge just after it is accepted
  task automatic applyStimulus(input logic signed [4:0] a, input logic signed [7:0] c);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    inp      = a;
    coef     = c;
    n        = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkFlag("accept_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkFlag(tag, out_valid, 1'b1);
  endtask

  task automatic finishHandshake(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkFlag(tag, out_valid, 1'b0);
  endtask

  task automatic runTrunc(input logic signed [4:0] a, input logic signed [7:0] c,
                          input logic [12:0] exp, input string tag);
    int n;
    @(negedge clk);
    t_in_valid = 1'b1;
    t_inp      = a;
    t_coef     = c;
    @(negedge clk);
    t_in_valid = 1'b0;
    checkFlag("trunc_busy", t_busy, 1'b1);
    n = 0;
    while (!t_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkFlag("trunc_done", t_out_valid, 1'b1);
    checkOutput(tag, t_out, exp);
    t_out_ready = 1'b1;
    @(negedge clk);
    t_out_ready = 1'b0;
  endtask

  initial begin
    int                 bc;
    int                 prod;
    int                 stall;
    logic signed [4:0]  ra;
    logic signed [7:0]  rc;
    logic        [12:0] exp13;

    rst         = 1'b1;
    in_valid    = 1'b0;
    inp         = '0;
    coef        = '0;
    out_ready   = 1'b0;
    t_in_valid  = 1'b0;
    t_inp       = '0;
    t_coef      = '0;
    t_out_ready = 1'b0;

    repeat (2) @(negedge clk);
    checkFlag("rst_in_ready", in_ready, 1'b0);
    checkFlag("rst_out_valid", out_valid, 1'b0);
    checkFlag("rst_busy", busy, 1'b0);
    checkOutput("rst_out", out, 13'd0);
    rst = 1'b0;
    #1;
    checkFlag("idle_in_ready", in_ready, 1'b1);

    // Exact product, latency and busy length
    applyStimulus(5'sd7, 8'sd100);
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    checkOutput("busy_cycles", 13'(bc), 13'd8);
    checkFlag("done_valid", out_valid, 1'b1);
    checkOutput("prod_7x100", out, 13'd700);

    // Backpressure with a competing request that must be ignored
    in_valid = 1'b1;
    inp      = 5'sd3;
    coef     = 8'sd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkFlag("bp_valid", out_valid, 1'b1);
      checkOutput("bp_out", out, 13'd700);
      checkFlag("bp_in_ready", in_ready, 1'b0);
      checkFlag("bp_busy", busy, 1'b0);
    end
    out_ready = 1'b1;
    inp       = -5'sd1;
    coef      = 8'sd1;
    @(negedge clk);
    out_ready = 1'b0;
    checkFlag("hs_valid_drop", out_valid, 1'b0);
    checkFlag("hs_in_ready", in_ready, 1'b1);
    checkOutput("hs_out_hold", out, 13'd700);
    @(negedge clk);
    in_valid = 1'b0;
    checkFlag("resume_busy", busy, 1'b1);
    waitDone("done_m1x1");
    checkOutput("prod_m1x1", out, 13'h1FFF);
    finishHandshake("hs_m1x1");

    // Most negative operands
    applyStimulus(-5'sd16, -8'sd128);
    waitDone("done_m16xm128");
    checkOutput("prod_m16xm128", out, 13'd2048);
    finishHandshake("hs_m16xm128");

    // Reset sampled on the k=3 iteration edge
    applyStimulus(5'sd5, 8'sd9);
    repeat (3) @(negedge clk);
    checkFlag("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkFlag("abort_valid", out_valid, 1'b0);
    checkOutput("abort_out", out, 13'd0);
    checkFlag("abort_in_ready", in_ready, 1'b1);
    checkFlag("abort_busy", busy, 1'b0);
    applyStimulus(5'sd5, 8'sd9);
    waitDone("done_5x9");
    checkOutput("prod_5x9", out, 13'd45);
    finishHandshake("hs_5x9");

    // Truncated instance: two low columns dropped from every partial product
    runTrunc(5'sd3, 8'sd3, 13'd4, "trunc_3x3");
    runTrunc(-5'sd1, 8'sd1, 13'h1FFC, "trunc_m1x1");

    // Random pairs against an integer reference with random result stalls
    for (int it = 0; it < 200; it++) begin
      ra    = 5'($urandom_range(0, 31));
      rc    = 8'($urandom_range(0, 255));
      prod  = int'(ra) * int'(rc);
      exp13 = prod[12:0];
      applyStimulus(ra, rc);
      waitDone("rand_done");
      checkOutput("rand_prod", out, exp13);
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        checkFlag("rand_stall_valid", out_valid, 1'b1);
        checkOutput("rand_stall_out", out, exp13);
      end
      finishHandshake("rand_hs");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
